cnt_pair_checker: RTL and testbench
===================================

# cnt_pair_checker

Downstream checking stage for the 4-bit counter/delay pair produced by the counter stage. The counter stage produces `a` (incrementing) and `b` (`a` delayed by one clock). This block samples each valid pair and checks two rules. Rule A: `a == b + 1` mod 2^W. Rule B: `b` equals the previously accepted `a`. It counts mismatches and wrap-arounds and buffers mismatch records in a small FIFO for readout by the bench or a CSR stage.

## Interface
Parameters:
- `W`, 4, data width of `a`/`b`.
- `ERR_CNT_W`, 8, width of saturating error and wrap counters.
- `LOG_DEPTH`, 4, mismatch-log FIFO depth (power of 2, ≥2).

Ports:
- `clk`, in, 1, single clock; all state on rising edge.
- `rst`, in, 1, reset, asynchronous assert, active-high.
- `clr`, in, 1, synchronous clear: counters, FSM, FIFO and sticky flags back to reset values.
- `in_valid`, in, 1, pair valid; sampled every cycle (no backpressure).
- `in_a`, in, W, counter value.
- `in_b`, in, W, delayed counter value.
- `err_pulse`, out, 1, one-cycle pulse, registered, on any rule failure.
- `err_cnt`, out, ERR_CNT_W, saturating mismatch count.
- `wrap_cnt`, out, ERR_CNT_W, saturating count of accepted `a` transitions from 2^W−1 to 0.
- `state`, out, 2, FSM state (IDLE=0, PRIME=1, TRACK=2).
- `log_valid`, out, 1, FIFO non-empty.
- `log_ready`, in, 1, consumer pops the head when `log_valid && log_ready`.
- `log_data`, out, 3W, head record {`in_a`, `in_b`, expected_b}.
- `log_ovf`, out, 1, sticky; a record was dropped because the FIFO was full.

## Operation
FSM:
- **IDLE**
  - Reset/clr state. `prev_a` is invalid.
  - On `in_valid`: capture `prev_a=in_a`, check Rule A only, go to PRIME.
- **PRIME**
  - On `in_valid`: check Rules A and B, update `prev_a`, go to TRACK.
  - PRIME exists so the first post-reset pair is never Rule B-checked.
- **TRACK**
  - Every `in_valid`: check Rules A and B, update `prev_a`.
  - Remains in TRACK after mismatches; self-resyncs from the new `prev_a`.

Per accepted pair:
- expected_b equals `prev_a` in PRIME/TRACK and `in_a−1` mod 2^W in IDLE.
- Fail = Rule A fail OR (state≠IDLE AND Rule B fail). One fail per pair, even if both rules break.
- On fail:
  - `err_cnt` increments, saturating at 2^ERR_CNT_W−1 with no wrap.
  - A record is pushed to the FIFO.
- Wrap is counted when state≠IDLE, `prev_a==2^W−1` and `in_a==0`.
- Arithmetic is mod 2^W. Comparisons are exact W-bit.

FIFO:
- Push and pop in the same cycle with the FIFO full: the pop frees a slot and the push is accepted, so there is no overflow.
- Push while full without a pop: the record is dropped and `log_ovf` is set. `log_ovf` clears only on `rst` or `clr`.
- Pop while empty is ignored.

Reset and clear:
- `rst` asserted (async) or `clr` (sync) gives: `state`=IDLE, `err_cnt`=0, `wrap_cnt`=0, `err_pulse`=0, `log_valid`=0, `log_data`=0, `log_ovf`=0, `prev_a`=0.
- `clr` has priority over a same-cycle `in_valid`; that pair is discarded.

## Timing
- Latency is 1 cycle. For a pair accepted at edge N, `err_pulse`, `err_cnt`, `wrap_cnt`, `state` and the FIFO push are all visible after edge N.
- `log_valid` rises the cycle after the push.
- `log_data` is the registered head and is stable while `log_valid && !log_ready`.
- Back-to-back fails produce back-to-back `err_pulse` highs, with no merging.
- `in_valid` low: no state change, `err_pulse`=0.
- Reset deassertion is synchronous to `clk` at the instantiating level. Reset asserted mid-stream aborts immediately with no partial FIFO write.

## Configuration
- `CNT_PAIR_CHK_LOG_EN` defined:
  - FIFO, `log_*` ports and `log_ovf` are fully implemented as above.
- `CNT_PAIR_CHK_LOG_EN` undefined:
  - No FIFO storage is built.
  - `log_valid`=0, `log_data`=0 and `log_ovf`=0 constantly; `log_ready` is ignored.
  - Counters, FSM and `err_pulse` are unchanged.

## Test plan
- Clean stream after reset: pairs (1,0),(2,1)…(15,14),(0,15),(1,0) → `err_cnt`=0, `wrap_cnt`=1, `state`: IDLE→PRIME→TRACK, no `log_valid`.
- Rule B fail: in TRACK with `prev_a`=5, drive (6,4) → `err_pulse` 1 cycle, `err_cnt`=1, `log_data`={6,4,5}.
- Rule A fail on first pair: from IDLE drive (3,3) → `err_cnt`=1, record {3,3,2}, state=PRIME; no Rule B check on this pair.
- FIFO overflow (LOG_DEPTH=4, `log_ready`=0): 5 consecutive failing pairs → `err_cnt`=5, 4 records held, `log_ovf`=1. Then pop and push in the same cycle while full → no further drop.
- Saturation: 300 failing pairs with ERR_CNT_W=8 → `err_cnt` holds at 255 and `err_pulse` still pulses each cycle.
- Reset/clear mid-operation: assert `rst` asynchronously between edges while in TRACK with records queued → all outputs 0 immediately. Then `clr` with a same-cycle `in_valid` → pair discarded, state=IDLE.

Source files
------------

// File: rtl/cnt_pair_checker_if.sv
// cnt_pair_checker_if: pair input, checker status and mismatch-log bus; master drives pairs/log_ready, slave is the checker
interface cnt_pair_checker_if #(
  parameter int W = 4,
  parameter int ERR_CNT_W = 8
);
  logic in_valid;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic err_pulse;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic [ERR_CNT_W-1:0] wrap_cnt;
  logic [1:0] state;
  logic log_valid;
  logic log_ready;
  logic [3*W-1:0] log_data;
  logic log_ovf;
  modport master (
    output in_valid, in_a, in_b, log_ready,
    input err_pulse, err_cnt, wrap_cnt, state, log_valid, log_data, log_ovf
  );
  modport slave (
    input in_valid, in_a, in_b, log_ready,
    output err_pulse, err_cnt, wrap_cnt, state, log_valid, log_data, log_ovf
  );
endinterface

// File: rtl/cnt_pair_checker.sv
// cnt_pair_checker: checks a==b+1 and b==prev a on counter pairs; ports clk, rst (async), clr (sync), bus (slave: pair in, err/wrap counters, state, mismatch log); CNT_PAIR_CHK_LOG_EN builds the log FIFO
module cnt_pair_checker #(
  parameter int W = 4,
  parameter int ERR_CNT_W = 8,
  parameter int LOG_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  input logic clr,
  cnt_pair_checker_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, TRACK = 2'd2} state_t;
  state_t r_state, w_next;
  logic [W-1:0] r_prev_a, w_exp_b;
  logic w_acc, w_fail, w_wrap;
  logic r_err_pulse;
  logic [ERR_CNT_W-1:0] r_err_cnt, r_wrap_cnt;
  always_comb begin
    w_acc = bus.in_valid & ~clr;
    w_exp_b = (r_state == IDLE) ? bus.in_a - W'(1) : r_prev_a;
    w_fail = (bus.in_a != bus.in_b + W'(1)) | ((r_state != IDLE) & (bus.in_b != r_prev_a));
    w_wrap = (r_state != IDLE) & (&r_prev_a) & (bus.in_a == '0);
    w_next = clr ? IDLE : !bus.in_valid ? r_state : (r_state == IDLE) ? PRIME : TRACK;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clr) begin
      r_prev_a <= '0;
      r_err_pulse <= 1'b0;
      r_err_cnt <= '0;
      r_wrap_cnt <= '0;
    end else begin
      r_err_pulse <= bus.in_valid & w_fail;
      if (bus.in_valid) r_prev_a <= bus.in_a;
      if (bus.in_valid & w_fail & ~&r_err_cnt) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      if (bus.in_valid & w_wrap & ~&r_wrap_cnt) r_wrap_cnt <= r_wrap_cnt + ERR_CNT_W'(1);
    end
  end
  assign bus.err_pulse = r_err_pulse;
  assign bus.err_cnt = r_err_cnt;
  assign bus.wrap_cnt = r_wrap_cnt;
  assign bus.state = r_state;
`ifdef CNT_PAIR_CHK_LOG_EN
  localparam int PW = $clog2(LOG_DEPTH);
  logic [3*W-1:0] r_mem [LOG_DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [PW:0] r_cnt;
  logic r_ovf, w_pop, w_push, w_wr_ok;
  always_comb begin
    w_pop = bus.log_ready & (r_cnt != '0) & ~clr;
    w_push = w_acc & w_fail;
    w_wr_ok = w_push & ((r_cnt != (PW+1)'(LOG_DEPTH)) | w_pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clr) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr <= r_wr + PW'(1);
      if (w_pop) r_rd <= r_rd + PW'(1);
      r_cnt <= r_cnt + {{PW{1'b0}}, w_wr_ok} - {{PW{1'b0}}, w_pop};
      if (w_push & ~w_wr_ok) r_ovf <= 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (w_wr_ok && !rst) r_mem[r_wr] <= {bus.in_a, bus.in_b, w_exp_b};
  assign bus.log_valid = r_cnt != '0;
  assign bus.log_data = (r_cnt != '0) ? r_mem[r_rd] : '0;
  assign bus.log_ovf = r_ovf;
`else
  logic w_unused;
  assign w_unused = ^{bus.log_ready, w_exp_b};
  assign bus.log_valid = 1'b0;
  assign bus.log_data = '0;
  assign bus.log_ovf = 1'b0;
`endif
endmodule

// File: tb/tb_cnt_pair_checker.sv
// tb_cnt_pair_checker: scoreboard bench for cnt_pair_checker against an independent behavioural model
module tb_cnt_pair_checker;
  localparam int W = 4, EW = 8, D = 4;
  logic clk = 1'b0, rst = 1'b1, clr = 1'b0;
  always #5 clk = ~clk;
  cnt_pair_checker_if #(.W(W), .ERR_CNT_W(EW)) bus();
  cnt_pair_checker #(.W(W), .ERR_CNT_W(EW), .LOG_DEPTH(D)) dut (.clk(clk), .rst(rst), .clr(clr), .bus(bus));
  typedef struct packed {
    logic p;
    logic [EW-1:0] e;
    logic [EW-1:0] w;
    logic [1:0] s;
    logic lv;
    logic ovf;
    logic [3*W-1:0] d;
  } exp_t;
  exp_t sb[$];
  logic [3*W-1:0] m_fifo[$];
  int n_chk = 0, n_fail = 0;
  logic [1:0] m_state;
  logic [W-1:0] m_prev;
  int m_err, m_wrap;
  logic m_ovf;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask
  task automatic m_clear();
    m_state = 2'd0;
    m_prev = '0;
    m_err = 0;
    m_wrap = 0;
    m_ovf = 1'b0;
    m_fifo.delete();
  endtask
  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic rdy = 1'b0, input logic c = 1'b0);
    logic fail;
    logic pulse;
    logic [W-1:0] bp1, eb;
    exp_t e;
    bus.in_valid = v;
    bus.in_a = a;
    bus.in_b = b;
    bus.log_ready = rdy;
    clr = c;
    pulse = 1'b0;
    if (c) m_clear();
    else begin
`ifdef CNT_PAIR_CHK_LOG_EN
      if (rdy && m_fifo.size() > 0) void'(m_fifo.pop_front());
`endif
      if (v) begin
        bp1 = b + 1;
        eb = (m_state == 2'd0) ? a - 1 : m_prev;
        fail = (bp1 != a) || (m_state != 2'd0 && b != m_prev);
        if (m_state != 2'd0 && m_prev == 15 && a == 0 && m_wrap < 255) m_wrap++;
        if (fail) begin
          pulse = 1'b1;
          if (m_err < 255) m_err++;
`ifdef CNT_PAIR_CHK_LOG_EN
          if (m_fifo.size() < D) m_fifo.push_back({a, b, eb});
          else m_ovf = 1'b1;
`endif
        end
        m_prev = a;
        m_state = (m_state == 2'd0) ? 2'd1 : 2'd2;
      end
    end
    e.p = pulse;
    e.e = m_err[EW-1:0];
    e.w = m_wrap[EW-1:0];
    e.s = m_state;
    e.lv = m_fifo.size() > 0;
    e.ovf = m_ovf;
    e.d = (m_fifo.size() > 0) ? m_fifo[0] : '0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    clr = 1'b0;
    e = sb.pop_front();
    chk("err_pulse", 32'(bus.err_pulse), 32'(e.p));
    chk("err_cnt", 32'(bus.err_cnt), 32'(e.e));
    chk("wrap_cnt", 32'(bus.wrap_cnt), 32'(e.w));
    chk("state", 32'(bus.state), 32'(e.s));
    chk("log_valid", 32'(bus.log_valid), 32'(e.lv));
    chk("log_ovf", 32'(bus.log_ovf), 32'(e.ovf));
    chk("log_data", 32'(bus.log_data), 32'(e.d));
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, 32'(bus.state), 0);
    chk({tag, "_err"}, 32'(bus.err_cnt), 0);
    chk({tag, "_wrap"}, 32'(bus.wrap_cnt), 0);
    chk({tag, "_pulse"}, 32'(bus.err_pulse), 0);
    chk({tag, "_lv"}, 32'(bus.log_valid), 0);
    chk({tag, "_ld"}, 32'(bus.log_data), 0);
    chk({tag, "_ovf"}, 32'(bus.log_ovf), 0);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.log_ready = 1'b0;
    m_clear();
    #12;
    chk_zero("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 1; k < 16; k++) step(1'b1, W'(k), W'(k - 1));
    step(1'b1, 4'd0, 4'd15);
    step(1'b1, 4'd1, 4'd0);
    chk("clean_err", 32'(bus.err_cnt), 0);
    chk("clean_wrap", 32'(bus.wrap_cnt), 1);
    chk("clean_state", 32'(bus.state), 2);
    for (int k = 2; k < 6; k++) step(1'b1, W'(k), W'(k - 1));
    step(1'b1, 4'd6, 4'd4);
    chk("ruleb_err", 32'(bus.err_cnt), 1);
`ifdef CNT_PAIR_CHK_LOG_EN
    chk("ruleb_rec", 32'(bus.log_data), 32'({4'd6, 4'd4, 4'd5}));
`endif
    step(1'b0, 4'd0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    step(1'b1, 4'd3, 4'd3);
    chk("rulea_err", 32'(bus.err_cnt), 1);
    chk("rulea_state", 32'(bus.state), 1);
`ifdef CNT_PAIR_CHK_LOG_EN
    chk("rulea_rec", 32'(bus.log_data), 32'({4'd3, 4'd3, 4'd2}));
`endif
    step(1'b0, 4'd0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    for (int k = 3; k < 7; k++) step(1'b1, W'(k), W'(k));
    step(1'b1, 4'd9, 4'd9, 1'b1);
    step(1'b1, 4'd11, 4'd11);
    chk("ovf_err", 32'(bus.err_cnt), 6);
    for (int k = 0; k < 4; k++) step(1'b0, 4'd0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    for (int k = 0; k < 300; k++) step(1'b1, W'(k), W'(k));
    chk("sat_err", 32'(bus.err_cnt), 255);
    step(1'b0, 4'd0, 4'd0);
    step(1'b1, 4'd2, 4'd2);
    chk("sat_pulse", 32'(bus.err_pulse), 1);
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    step(1'b1, 4'd1, 4'd0);
    step(1'b1, 4'd2, 4'd1);
    step(1'b1, 4'd3, 4'd2);
    step(1'b1, 4'd7, 4'd7);
    bus.in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk_zero("arst");
    m_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 4'd4, 4'd3);
    step(1'b1, 4'd5, 4'd5, 1'b0, 1'b1);
    chk("clr_state", 32'(bus.state), 0);
    step(1'b1, 4'd1, 4'd0);
    chk("post_clr_state", 32'(bus.state), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
